fir_sample_streamer: RTL and testbench
======================================

# fir_sample_streamer

Streaming source for the FIR/matched-filter datapath: it holds a block of signed samples written by a host port and, on command, plays them out on the filter's input interface (`dataIn`/`loadDataFlag`/`stopDataLoadFlag`). After the samples it sends a tail of zero samples so the filter's delay line drains, then asserts the stop flag for one cycle. It sits directly upstream of the FIR. It is the transmitting end of the interface the filter receives.

## Interface
- `DATA_WIDTH`, 8, sample width, signed two's complement.
- `DEPTH`, 64, sample buffer entries. Must be a power of two and at least 2.
- `FLUSH_LENGTH`, 20, number of zero samples sent after the data. Set it equal to the FIR `LENGTH`. Legal range is 0 or more.
- `SAMPLE_PERIOD`, 1, clock cycles between successive `loadDataFlag` pulses. Must be at least 1.
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `writeEnable`  in  1  writes `writeData` to `writeAddress` on this edge. Ignored while `busy`.
- `writeAddress`  in  log2(DEPTH)  buffer write address.
- `writeData`  in  DATA_WIDTH signed  sample to store.
- `start`  in  1  launches one playback. Ignored unless in IDLE.
- `numSamples`  in  log2(DEPTH)+1  samples to play, captured with `start`. Values above DEPTH are clamped to DEPTH.
- `dataOut`  out  DATA_WIDTH signed  sample to the FIR `dataIn`.
- `loadDataFlag`  out  1  one-cycle strobe; `dataOut` is valid in the same cycle.
- `stopDataLoadFlag`  out  1  one-cycle end-of-block strobe.
- `busy`  out  1  playback in progress.

## Operation
- Buffer: register array of DEPTH × DATA_WIDTH.
  - Contents are not cleared by reset.
  - Writes happen only in IDLE.
- State machine:
  - **IDLE:** on `start`, latch N = min(`numSamples`, DEPTH), clear the index and pace counter, and go to STREAM. If N = 0, go to FLUSH instead.
  - **STREAM:** emit `buffer[index]` for index = 0..N-1, one strobe per SAMPLE_PERIOD. After strobe N-1, go to FLUSH.
  - **FLUSH:** emit FLUSH_LENGTH strobes with `dataOut` = 0 at the same pacing, then go to STOP. If FLUSH_LENGTH = 0, go straight to STOP.
  - **STOP:** `stopDataLoadFlag` = 1 for exactly one cycle, then go to IDLE.
  - **Unused encodings:** return to IDLE with all outputs 0.
- Pacing counter:
  - Counts 0..SAMPLE_PERIOD-1.
  - A strobe fires on the cycle the counter reaches 0.
  - It is continuous across the STREAM→FLUSH→STOP transitions.
- Outputs are registered. `dataOut` is 0 whenever `loadDataFlag` is 0.
- `busy` = 1 in STREAM, FLUSH and STOP; 0 in IDLE.
- Simultaneous `writeEnable` and `start` in IDLE: the write takes effect and `start` is accepted. The playback may read that address; the written value must appear if that address is read at its strobe.
- Reset asserted at any time:
  - State goes to IDLE immediately (asynchronously).
  - `dataOut`, `loadDataFlag`, `stopDataLoadFlag` and `busy` go to 0.
  - No stop strobe is emitted for an aborted block.
  - Operation resumes on the first rising edge after reset deasserts.

## Timing
- Reset values: `dataOut` = 0, `loadDataFlag` = 0, `stopDataLoadFlag` = 0, `busy` = 0.
- Let `start` be sampled at edge k, with period P = SAMPLE_PERIOD, flush length F = FLUSH_LENGTH and N = the latched sample count.
- `busy` = 1 from edge k+1.
- Data strobe i (0 ≤ i < N) occurs at edge k+1+i·P.
- Flush strobe j (0 ≤ j < F) occurs at edge k+1+(N+j)·P.
- `stopDataLoadFlag` is asserted at edge k+1+(N+F)·P.
- `busy` falls at the following edge. A new `start` is accepted from that edge onward.
- Back-to-back blocks: minimum gap is one IDLE cycle between the stop strobe and the next first strobe.
- `loadDataFlag` and `stopDataLoadFlag` are never high in the same cycle.

## Test plan
- **Basic playback:** write 1,2,3,4 to addresses 0–3; P=1, F=2; `start` with N=4 → strobes on 6 consecutive cycles with `dataOut` = 1,2,3,4,0,0, stop on the next cycle, then `busy` = 0.
- **Pacing:** P=3, N=2, F=1, data −5,7 → strobes at k+1, k+4, k+7 with values −5,7,0; stop at k+10; `dataOut` = 0 between strobes.
- **Edge counts:**
  - N=0 → F zero strobes, then stop.
  - N=100 with DEPTH=64 → exactly 64 data strobes.
  - F=0 → stop directly follows the last data pacing slot.
- **Ignored inputs while busy:** `start` and writes during playback → no restart, buffer unchanged; a replay returns the original data.
- **Reset mid-stream:** assert reset after strobe 2 → outputs 0 immediately, no stop strobe; after release, a new `start` plays from index 0 and the buffer is intact.
- **FIR integration:** drive the FIR with an impulse (127, then zeros) → FIR output sequence equals its coefficients × 127 in order; the FIR reaches its stop state on `stopDataLoadFlag`.

Source files
------------

// File: rtl/fir_sample_streamer.sv
// Sample source for the FIR input interface: buffers host-written samples and
// plays a block out at a fixed pace, then a zero tail and a one-cycle stop strobe.
module fir_sample_streamer #(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 64,
  parameter int FLUSH_LENGTH  = 20,
  parameter int SAMPLE_PERIOD = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          writeEnable,
  input  logic [$clog2(DEPTH)-1:0]      writeAddress,
  input  logic signed [DATA_WIDTH-1:0]  writeData,
  input  logic                          start,
  input  logic [$clog2(DEPTH):0]        numSamples,
  output logic signed [DATA_WIDTH-1:0]  dataOut,
  output logic                          loadDataFlag,
  output logic                          stopDataLoadFlag,
  output logic                          busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int FW = (FLUSH_LENGTH > 1) ? $clog2(FLUSH_LENGTH) : 1;

  localparam logic [PW-1:0] PACE_LAST  = PW'(SAMPLE_PERIOD - 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_LENGTH - 1);
  localparam logic [AW:0]   DEPTH_N    = (AW + 1)'(DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_STREAM = 3'd1;
  localparam logic [2:0] S_FLUSH  = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;

  logic signed [DATA_WIDTH-1:0] mem [DEPTH];

  logic [2:0]    state, state_n;
  logic [AW-1:0] index, index_n;
  logic [AW-1:0] last_idx, last_idx_n;
  logic [FW-1:0] flush_cnt, flush_cnt_n;
  logic [PW-1:0] pace, pace_n, pace_adv;
  logic [AW:0]   n_clamped;

  logic                         load_n, stop_n, busy_n;
  logic signed [DATA_WIDTH-1:0] data_n;

  // Buffer has no reset; writes are only accepted while idle.
  always_ff @(posedge clock) begin
    if (writeEnable && (state == S_IDLE)) begin
      mem[writeAddress] <= writeData;
    end
  end

  always_comb begin
    n_clamped = (numSamples > DEPTH_N) ? DEPTH_N : numSamples;
    pace_adv  = (pace == PACE_LAST) ? '0 : pace + 1'b1;
  end

  // Pace counter free-runs through STREAM/FLUSH/STOP so slot spacing never slips.
  always_comb begin
    state_n     = state;
    index_n     = index;
    last_idx_n  = last_idx;
    flush_cnt_n = flush_cnt;
    pace_n      = pace;
    load_n      = 1'b0;
    stop_n      = 1'b0;
    data_n      = '0;
    busy_n      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          index_n     = '0;
          flush_cnt_n = '0;
          pace_n      = '0;
          last_idx_n  = AW'(n_clamped - 1'b1);
          if (n_clamped != '0) begin
            state_n = S_STREAM;
          end else if (FLUSH_LENGTH == 0) begin
            state_n = S_STOP;
          end else begin
            state_n = S_FLUSH;
          end
        end
      end
      S_STREAM: begin
        busy_n = 1'b1;
        pace_n = pace_adv;
        if (pace == '0) begin
          load_n  = 1'b1;
          data_n  = mem[index];
          index_n = index + 1'b1;
          if (index == last_idx) begin
            state_n = (FLUSH_LENGTH == 0) ? S_STOP : S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        busy_n = 1'b1;
        pace_n = pace_adv;
        if (pace == '0) begin
          load_n      = 1'b1;
          flush_cnt_n = flush_cnt + 1'b1;
          if (flush_cnt == FLUSH_LAST) begin
            state_n = S_STOP;
          end
        end
      end
      S_STOP: begin
        busy_n = 1'b1;
        pace_n = pace_adv;
        if (pace == '0) begin
          stop_n  = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state            <= S_IDLE;
      index            <= '0;
      last_idx         <= '0;
      flush_cnt        <= '0;
      pace             <= '0;
      dataOut          <= '0;
      loadDataFlag     <= 1'b0;
      stopDataLoadFlag <= 1'b0;
      busy             <= 1'b0;
    end else begin
      state            <= state_n;
      index            <= index_n;
      last_idx         <= last_idx_n;
      flush_cnt        <= flush_cnt_n;
      pace             <= pace_n;
      dataOut          <= data_n;
      loadDataFlag     <= load_n;
      stopDataLoadFlag <= stop_n;
      busy             <= busy_n;
    end
  end

endmodule

// File: tb/tb_fir_sample_streamer.sv
// Directed bench for fir_sample_streamer: three instances with different
// pacing/flush settings share one stimulus port.
module tb_fir_sample_streamer;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              writeEnable = 1'b0;
  logic [5:0]        writeAddress = '0;
  logic signed [7:0] writeData = '0;
  logic              start = 1'b0;
  logic [6:0]        numSamples = '0;

  logic signed [7:0] a_data, b_data, c_data;
  logic a_load, a_stop, a_busy;
  logic b_load, b_stop, b_busy;
  logic c_load, c_stop, c_busy;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  // A: P=1 F=2, B: P=3 F=1, C: P=2 F=0
  fir_sample_streamer #(.DATA_WIDTH(8), .DEPTH(64), .FLUSH_LENGTH(2), .SAMPLE_PERIOD(1)) dut_a (
    .clock(clock), .reset(reset), .writeEnable(writeEnable), .writeAddress(writeAddress),
    .writeData(writeData), .start(start), .numSamples(numSamples),
    .dataOut(a_data), .loadDataFlag(a_load), .stopDataLoadFlag(a_stop), .busy(a_busy));

  fir_sample_streamer #(.DATA_WIDTH(8), .DEPTH(64), .FLUSH_LENGTH(1), .SAMPLE_PERIOD(3)) dut_b (
    .clock(clock), .reset(reset), .writeEnable(writeEnable), .writeAddress(writeAddress),
    .writeData(writeData), .start(start), .numSamples(numSamples),
    .dataOut(b_data), .loadDataFlag(b_load), .stopDataLoadFlag(b_stop), .busy(b_busy));

  fir_sample_streamer #(.DATA_WIDTH(8), .DEPTH(64), .FLUSH_LENGTH(0), .SAMPLE_PERIOD(2)) dut_c (
    .clock(clock), .reset(reset), .writeEnable(writeEnable), .writeAddress(writeAddress),
    .writeData(writeData), .start(start), .numSamples(numSamples),
    .dataOut(c_data), .loadDataFlag(c_load), .stopDataLoadFlag(c_stop), .busy(c_busy));

  typedef struct {
    logic we;
    int   addr;
    int   wd;
    logic st;
    int   n;
    logic e_load;
    int   e_data;
    logic e_stop;
    logic e_busy;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic we, input int addr, input int wd, input logic st, input int n,
                     input logic el, input int ed, input logic es, input logic eb);
    vec_t v;
    v.we = we; v.addr = addr; v.wd = wd; v.st = st; v.n = n;
    v.e_load = el; v.e_data = ed; v.e_stop = es; v.e_busy = eb;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    writeEnable = 1'b0;
    start       = 1'b0;
    writeAddress = '0;
    writeData   = '0;
    numSamples  = '0;
  endtask

  function automatic logic signed [7:0] pat(input int i);
    return 8'(i * 2 - 64);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nload;
    int stop_t;
    int exp_d;
    logic exp_l;

    // Table for instance A; each row's expectations are sampled after its edge.
    add(1, 0, 1, 0, 0,  0, 0, 0, 0);
    add(1, 1, 2, 0, 0,  0, 0, 0, 0);
    add(1, 2, 3, 0, 0,  0, 0, 0, 0);
    add(1, 3, 4, 0, 0,  0, 0, 0, 0);
    add(0, 0, 0, 1, 4,  0, 0, 0, 0);
    add(0, 0, 0, 0, 0,  1, 1, 0, 1);
    add(0, 0, 0, 0, 0,  1, 2, 0, 1);
    add(1, 0, 99, 1, 2, 1, 3, 0, 1);
    add(0, 0, 0, 0, 0,  1, 4, 0, 1);
    add(0, 0, 0, 0, 0,  1, 0, 0, 1);
    add(0, 0, 0, 0, 0,  1, 0, 0, 1);
    add(0, 0, 0, 0, 0,  0, 0, 1, 1);
    add(0, 0, 0, 0, 0,  0, 0, 0, 0);
    add(0, 0, 0, 1, 2,  0, 0, 0, 0);
    add(0, 0, 0, 0, 0,  1, 1, 0, 1);
    add(0, 0, 0, 0, 0,  1, 2, 0, 1);
    add(0, 0, 0, 0, 0,  1, 0, 0, 1);
    add(0, 0, 0, 0, 0,  1, 0, 0, 1);
    add(0, 0, 0, 0, 0,  0, 0, 1, 1);
    add(0, 0, 0, 0, 0,  0, 0, 0, 0);
    add(1, 0, -9, 1, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0,  1, -9, 0, 1);
    add(0, 0, 0, 0, 0,  1, 0, 0, 1);
    add(0, 0, 0, 0, 0,  1, 0, 0, 1);
    add(0, 0, 0, 0, 0,  0, 0, 1, 1);
    add(0, 0, 0, 1, 0,  0, 0, 0, 0);
    add(0, 0, 0, 0, 0,  1, 0, 0, 1);
    add(0, 0, 0, 0, 0,  1, 0, 0, 1);
    add(0, 0, 0, 0, 0,  0, 0, 1, 1);
    add(0, 0, 0, 0, 0,  0, 0, 0, 0);

    // Reset values
    tick();
    tick();
    chk("rst a_data", a_data, 0);
    chk("rst a_load", a_load, 0);
    chk("rst a_stop", a_stop, 0);
    chk("rst a_busy", a_busy, 0);
    chk("rst b_load", b_load, 0);
    chk("rst b_busy", b_busy, 0);
    chk("rst c_stop", c_stop, 0);
    chk("rst c_busy", c_busy, 0);
    reset = 1'b1;
    tick();

    foreach (vq[i]) begin
      writeEnable  = vq[i].we;
      writeAddress = 6'(vq[i].addr);
      writeData    = 8'(vq[i].wd);
      start        = vq[i].st;
      numSamples   = 7'(vq[i].n);
      tick();
      chk($sformatf("row%0d load", i), a_load, vq[i].e_load);
      chk($sformatf("row%0d data", i), a_data, vq[i].e_data);
      chk($sformatf("row%0d stop", i), a_stop, vq[i].e_stop);
      chk($sformatf("row%0d busy", i), a_busy, vq[i].e_busy);
    end
    idle_inputs();
    repeat (40) tick();

    // Pacing: B (P=3,F=1) and C (P=2,F=0) on data -5,7
    writeEnable = 1'b1; writeAddress = 6'd0; writeData = -8'sd5;
    tick();
    writeAddress = 6'd1; writeData = 8'sd7;
    tick();
    writeEnable = 1'b0; start = 1'b1; numSamples = 7'd2;
    tick();
    idle_inputs();
    for (int t = 1; t <= 11; t++) begin
      tick();
      exp_l = (t == 1 || t == 4 || t == 7);
      exp_d = (t == 1) ? -5 : (t == 4) ? 7 : 0;
      chk($sformatf("pace b t%0d load", t), b_load, exp_l);
      chk($sformatf("pace b t%0d data", t), b_data, exp_d);
      chk($sformatf("pace b t%0d stop", t), b_stop, (t == 10));
      chk($sformatf("pace b t%0d busy", t), b_busy, (t <= 10));
      exp_l = (t == 1 || t == 3);
      exp_d = (t == 1) ? -5 : (t == 3) ? 7 : 0;
      chk($sformatf("f0 c t%0d load", t), c_load, exp_l);
      chk($sformatf("f0 c t%0d data", t), c_data, exp_d);
      chk($sformatf("f0 c t%0d stop", t), c_stop, (t == 5));
      chk($sformatf("f0 c t%0d busy", t), c_busy, (t <= 5));
    end
    repeat (3) tick();

    // N = 0
    start = 1'b1; numSamples = 7'd0;
    tick();
    idle_inputs();
    for (int t = 1; t <= 5; t++) begin
      tick();
      chk($sformatf("n0 a t%0d load", t), a_load, (t <= 2));
      chk($sformatf("n0 a t%0d stop", t), a_stop, (t == 3));
      chk($sformatf("n0 b t%0d load", t), b_load, (t == 1));
      chk($sformatf("n0 b t%0d data", t), b_data, 0);
      chk($sformatf("n0 b t%0d stop", t), b_stop, (t == 4));
      chk($sformatf("n0 c t%0d load", t), c_load, 0);
      chk($sformatf("n0 c t%0d stop", t), c_stop, (t == 1));
      chk($sformatf("n0 c t%0d busy", t), c_busy, (t == 1));
    end

    // Clamp: N=100 on a 64-entry buffer
    writeEnable = 1'b1;
    for (int i = 0; i < 64; i++) begin
      writeAddress = 6'(i);
      writeData    = pat(i);
      tick();
    end
    writeEnable = 1'b0; start = 1'b1; numSamples = 7'd100;
    tick();
    idle_inputs();
    nload  = 0;
    stop_t = -1;
    for (int t = 1; t <= 70; t++) begin
      tick();
      if (a_load) begin
        if (nload < 64) chk($sformatf("clamp data %0d", nload), a_data, pat(nload));
        else chk($sformatf("clamp flush %0d", nload), a_data, 0);
        nload++;
      end
      if (a_stop && stop_t < 0) stop_t = t;
    end
    chk("clamp strobes", nload, 66);
    chk("clamp stop cycle", stop_t, 67);
    chk("clamp busy after", a_busy, 0);
    repeat (200) tick();

    // Reset mid-stream after strobe index 2
    start = 1'b1; numSamples = 7'd4;
    tick();
    idle_inputs();
    repeat (3) tick();
    chk("pre-reset strobe2", a_data, pat(2));
    #2 reset = 1'b0;
    #1;
    chk("abort load", a_load, 0);
    chk("abort data", a_data, 0);
    chk("abort stop", a_stop, 0);
    chk("abort busy", a_busy, 0);
    for (int t = 1; t <= 3; t++) begin
      tick();
      chk($sformatf("abort hold t%0d stop", t), a_stop, 0);
      chk($sformatf("abort hold t%0d load", t), a_load, 0);
    end
    #2 reset = 1'b1;
    tick();
    start = 1'b1; numSamples = 7'd4;
    tick();
    idle_inputs();
    for (int t = 1; t <= 8; t++) begin
      tick();
      exp_d = (t <= 4) ? int'(pat(t - 1)) : 0;
      chk($sformatf("resume t%0d load", t), a_load, (t <= 6));
      chk($sformatf("resume t%0d data", t), a_data, exp_d);
      chk($sformatf("resume t%0d stop", t), a_stop, (t == 7));
      chk($sformatf("resume t%0d busy", t), a_busy, (t <= 7));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
